// File: rtl/pipe_adder_dw.sv
// Pipelined add/subtract unit: DW-bit carry chain split into NSTAGE segments, one register per segment.
// Latency NSTAGE cycles (NSTAGE=1 is a registered adder); throughput one beat per cycle.
// Backpressure: en = !oValid || iReady freezes every stage, bubbles included; oReady = en.
//
// Ports:
//   iClk, iReset        clock (rising edge), synchronous active-high reset
//   iValid/oReady       operand handshake; iA, iB, iCin, iSub sampled only on transfer
//   oValid/iReady       result handshake; oZ, oCout, oOvf held stable while stalled
//   iSub=1 computes A-B (iCin ignored), iSub=0 computes A+B+iCin
//   oCout is the raw carry out of the MSB (subtract: 1 = no borrow); oOvf is signed overflow
//
// Optional build macro PIPE_ADDER_DW_SAT_EN: clamp oZ to the signed min/max on overflow
// at the last stage (oOvf and oCout unaffected). Without it oZ is the raw modulo result.

module pipe_adder_dw #(
    parameter int DW     = 16,
    parameter int NSTAGE = 4
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iValid,
    output logic          oReady,
    input  logic [DW-1:0] iA,
    input  logic [DW-1:0] iB,
    input  logic          iCin,
    input  logic          iSub,
    output logic          oValid,
    input  logic          iReady,
    output logic [DW-1:0] oZ,
    output logic          oCout,
    output logic          oOvf
);

    localparam int SEGW = DW / NSTAGE;
    localparam int LAST = NSTAGE - 1;

    // Per-stage state. a/b carry the full operands forward so the last stage
    // can see the operand sign bits; z accumulates result segments low to high.
    logic          vld_q [NSTAGE];
    logic [DW-1:0] a_q   [NSTAGE];
    logic [DW-1:0] b_q   [NSTAGE];
    logic [DW-1:0] z_q   [NSTAGE];
    logic          c_q   [NSTAGE];
    logic          ovf_q;

    // Next-state values; a_d/b_d/vld_d double as the inputs seen by each stage.
    logic          vld_d [NSTAGE];
    logic [DW-1:0] a_d   [NSTAGE];
    logic [DW-1:0] b_d   [NSTAGE];
    logic [DW-1:0] z_d   [NSTAGE];
    logic          c_d   [NSTAGE];
    logic          ovf_d;

    // Carry and partial result arriving at each stage from the one before.
    logic          cin_s [NSTAGE];
    logic [DW-1:0] zin_s [NSTAGE];

    logic [SEGW:0] seg_sum;
    logic          en;

    always_comb begin
        seg_sum = '0;
        ovf_d   = 1'b0;

        en = !vld_q[LAST] || iReady;

        // Subtract is A + ~B + 1, so the carry-in is forced to 1 and iCin dropped.
        a_d[0]   = iA;
        b_d[0]   = iSub ? ~iB : iB;
        cin_s[0] = iSub ? 1'b1 : iCin;
        zin_s[0] = '0;
        vld_d[0] = iValid;

        for (int k = 1; k < NSTAGE; k++) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            cin_s[k] = c_q[k-1];
            zin_s[k] = z_q[k-1];
            vld_d[k] = vld_q[k-1];
        end

        // Stage k resolves only bits [k*SEGW +: SEGW]; lower bits pass through.
        for (int k = 0; k < NSTAGE; k++) begin
            seg_sum = {1'b0, a_d[k][k*SEGW +: SEGW]}
                    + {1'b0, b_d[k][k*SEGW +: SEGW]}
                    + {{SEGW{1'b0}}, cin_s[k]};
            z_d[k]                  = zin_s[k];
            z_d[k][k*SEGW +: SEGW]  = seg_sum[SEGW-1:0];
            c_d[k]                  = seg_sum[SEGW];
        end

        // Overflow when both addends share a sign and the raw result's sign differs.
        ovf_d = (a_d[LAST][DW-1] == b_d[LAST][DW-1]) && (z_d[LAST][DW-1] != a_d[LAST][DW-1]);

`ifdef PIPE_ADDER_DW_SAT_EN
        // A non-negative A can only overflow upward, a negative A only downward.
        if (ovf_d) begin
            z_d[LAST] = a_d[LAST][DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                z_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < NSTAGE; k++) begin
                vld_q[k] <= vld_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                z_q[k]   <= z_d[k];
                c_q[k]   <= c_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign oReady = en;
    assign oValid = vld_q[LAST];
    assign oZ     = z_q[LAST];
    assign oCout  = c_q[LAST];
    assign oOvf   = ovf_q;

endmodule

// File: tb/tb_pipe_adder_dw.sv
module tb_pipe_adder_dw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit, 4-stage instance
    logic        v16, r16o, ov16, cin16, sub16, cout16, ovf16;
    logic        rdy16 = 1'b1;
    logic [15:0] a16, b16, z16;

    // 8-bit, 1-stage instance
    logic        v8, r8o, ov8, cin8, sub8, cout8, ovf8;
    logic        rdy8 = 1'b1;
    logic [7:0]  a8, b8, z8;

    pipe_adder_dw #(.DW(16), .NSTAGE(4)) u_dut16 (
        .iClk(clk), .iReset(rst), .iValid(v16), .oReady(r16o),
        .iA(a16), .iB(b16), .iCin(cin16), .iSub(sub16),
        .oValid(ov16), .iReady(rdy16), .oZ(z16), .oCout(cout16), .oOvf(ovf16)
    );

    pipe_adder_dw #(.DW(8), .NSTAGE(1)) u_dut8 (
        .iClk(clk), .iReset(rst), .iValid(v8), .oReady(r8o),
        .iA(a8), .iB(b8), .iCin(cin8), .iSub(sub8),
        .oValid(ov8), .iReady(rdy8), .oZ(z8), .oCout(cout8), .oOvf(ovf8)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] z;
        logic        cout;
        logic        ovf;
        int          stamp;
        bit          lat;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference: true signed/unsigned arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input bit cin, input bit sub, input int stamp, input bit lat);
        exp_t   e;
        longint ua, ub, sa, sb, full, us, maxv, minv, modv;
        modv = longint'(1) << w;
        maxv = (longint'(1) << (w - 1)) - 1;
        minv = -(longint'(1) << (w - 1));
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua > maxv) ? ua - modv : ua;
        sb   = (ub > maxv) ? ub - modv : ub;
        if (sub) begin
            full   = sa - sb;
            us     = ua - ub;
            e.cout = (ua >= ub);
        end else begin
            full   = sa + sb + longint'(cin);
            us     = ua + ub + longint'(cin);
            e.cout = (us >= modv);
        end
        e.ovf = (full > maxv) || (full < minv);
        e.z   = 16'(us & (modv - 1));
`ifdef PIPE_ADDER_DW_SAT_EN
        if (full > maxv)      e.z = 16'(maxv);
        else if (full < minv) e.z = 16'(minv & (modv - 1));
`endif
        e.stamp = stamp;
        e.lat   = lat;
        return e;
    endfunction

    // iReady driver for the 16-bit instance: 0 = always ready, 1 = random, 2 = stalled.
    int mode16 = 0;
    always @(posedge clk) begin
        #2;
        case (mode16)
            0:       rdy16 = 1'b1;
            1:       rdy16 = ($urandom_range(0, 3) != 0);
            default: rdy16 = 1'b0;
        endcase
    end

    // Monitor / scoreboard for the 16-bit instance.
    bit          stall16_prev = 1'b0;
    logic [15:0] pz16;
    logic        pc16, po16;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall16_prev = 1'b0;
        end else begin
            chk("oready16", {31'd0, r16o}, {31'd0, (!ov16 || rdy16)});
            if (stall16_prev) begin
                chk("hold_vld16",  {31'd0, ov16},   32'd1);
                chk("hold_z16",    {16'd0, z16},    {16'd0, pz16});
                chk("hold_cout16", {31'd0, cout16}, {31'd0, pc16});
                chk("hold_ovf16",  {31'd0, ovf16},  {31'd0, po16});
            end
            if (ov16 === 1'b1 && rdy16 === 1'b1) begin
                if (q16.size() == 0) begin
                    fail_now("out16_unexpected");
                end else begin
                    e = q16.pop_front();
                    chk("z16",    {16'd0, z16},    {16'd0, e.z});
                    chk("cout16", {31'd0, cout16}, {31'd0, e.cout});
                    chk("ovf16",  {31'd0, ovf16},  {31'd0, e.ovf});
                    if (e.lat) chk("lat16", cyc - e.stamp, 32'd3);
                end
            end
            stall16_prev = (ov16 === 1'b1) && (rdy16 === 1'b0);
            pz16 = z16;
            pc16 = cout16;
            po16 = ovf16;
        end
    end

    // Monitor / scoreboard for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov8 === 1'b1 && rdy8 === 1'b1) begin
            if (q8.size() == 0) begin
                fail_now("out8_unexpected");
            end else begin
                e = q8.pop_front();
                chk("z8",    {24'd0, z8},    {24'd0, e.z[7:0]});
                chk("cout8", {31'd0, cout8}, {31'd0, e.cout});
                chk("ovf8",  {31'd0, ovf8},  {31'd0, e.ovf});
                if (e.lat) chk("lat8", cyc - e.stamp, 32'd0);
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input bit cin, input bit sub,
                          input bit lat);
        bit rdy;
        int n;
        n   = 0;
        rdy = 1'b0;
        v16 = 1'b1; a16 = a; b16 = b; cin16 = cin; sub16 = sub;
        forever begin
            @(negedge clk);
            rdy = (r16o === 1'b1);
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 500) begin
                fail_now("send16_timeout");
                break;
            end
        end
        if (rdy) q16.push_back(model(16, a, b, cin, sub, cyc, lat));
        v16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit cin, input bit sub);
        bit rdy;
        int n;
        n   = 0;
        rdy = 1'b0;
        v8 = 1'b1; a8 = a; b8 = b; cin8 = cin; sub8 = sub;
        forever begin
            @(negedge clk);
            rdy = (r8o === 1'b1);
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 500) begin
                fail_now("send8_timeout");
                break;
            end
        end
        if (rdy) begin
            chk("fullrate8", n, 32'd0);
            q8.push_back(model(8, {8'd0, a}, {8'd0, b}, cin, sub, cyc, 1'b1));
        end
        v8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic drain16();
        int t;
        t = 0;
        while (q16.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain16", q16.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain8();
        int t;
        t = 0;
        while (q8.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain8", q8.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        v8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_vld16",  {31'd0, ov16},   32'd0);
        chk("rst_z16",    {16'd0, z16},    32'd0);
        chk("rst_cout16", {31'd0, cout16}, 32'd0);
        chk("rst_ovf16",  {31'd0, ovf16},  32'd0);
        chk("rst_rdy16",  {31'd0, r16o},   32'd1);
        chk("rst_vld8",   {31'd0, ov8},    32'd0);
        chk("rst_z8",     {24'd0, z8},     32'd0);

        // Directed corners, back to back, latency checked
        @(posedge clk);
        #1;
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send16(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
        send16(16'h1234, 16'h0FFF, 1'b1, 1'b0, 1'b1);
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send16(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        send16(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1);
        drain16();

        // Stream of 8 beats with a 3-cycle downstream stall once output appears
        fork
            begin
                for (int n = 1; n <= 8; n++)
                    send16(16'(n), 16'(16'h0100 * n), 1'b0, 1'b0, 1'b0);
            end
            begin
                int t;
                t = 0;
                while (ov16 !== 1'b1 && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 50) fail_now("stream_no_output");
                mode16 = 2;
                repeat (4) @(posedge clk);
                mode16 = 0;
            end
        join
        drain16();

        // Reset with beats in flight: all discarded, pipe restarts cleanly
        for (int n = 0; n < 3; n++)
            send16(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q16.delete();
        repeat (5) begin
            @(negedge clk);
            chk("flush_vld16", {31'd0, ov16}, 32'd0);
        end
        @(posedge clk);
        #1;
        send16(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
        drain16();

        // Randomised traffic with random gaps and random downstream back-pressure
        mode16 = 1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                send16(pick16(), pick16(), 1'($urandom), 1'($urandom), 1'b0);
            end
        end
        mode16 = 0;
        drain16();

        // Single-stage instance: corner then full-rate back-to-back beats
        send8(8'h80, 8'h80, 1'b0, 1'b0);
        send8(8'h7F, 8'h01, 1'b0, 1'b0);
        send8(8'h00, 8'h01, 1'b1, 1'b1);
        repeat (60) send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        drain8();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_adder_dw.md
Name: pipe_adder_dw

Overview:
Parameterised, pipelined add/subtract unit. It is the successor to the single-cycle half/full adders. The DW-bit carry chain is split into NSTAGE equal segments, one register stage per segment, with a valid/ready handshake on both sides and full back-pressure. It is the integer workhorse for mantissa add/align paths in the floating-point datapath.

Parameters:
DW, 16, operand/result width in bits; must be a multiple of NSTAGE, DW >= 2
NSTAGE, 4, pipeline stages = carry-chain segments; 1 <= NSTAGE <= DW; latency in cycles
SEGW, DW/NSTAGE, derived local, width of one segment; not overridable

Ports:
iClk  input  1  clock, rising edge
iReset  input  1  synchronous active-high reset
iValid  input  1  operand beat valid
oReady  output  1  unit can accept a beat this cycle
iA  input  DW  operand A (two's complement or unsigned)
iB  input  DW  operand B
iCin  input  1  carry-in (add mode only)
iSub  input  1  1 = A-B, 0 = A+B+iCin
oValid  output  1  result beat valid
iReady  input  1  downstream accepts result
oZ  output  DW  sum/difference
oCout  output  1  raw carry out of MSB (sub mode: 1 = no borrow)
oOvf  output  1  signed overflow

Behaviour:
- Clock, reset: one clock iClk. Reset is synchronous and active-high on iReset. All state updates on the iClk rising edge.
- Reset: all stage valid bits = 0; oValid=0, oZ=0, oCout=0, oOvf=0. oReady=1 in the cycle after reset deasserts.
- Operand preparation at input: B' = iSub ? ~iB : iB; c0 = iSub ? 1 : iCin (iCin ignored when iSub=1).
- Stage k (0..NSTAGE-1):
  - adds segment k of A and B' with the carry registered from stage k-1 (stage 0 uses c0).
  - registers the SEGW-bit partial result, carry out, and valid bit.
  - forwards the unconsumed upper segments of A and B' plus the already-computed lower result bits.
- Last stage:
  - oZ = the full DW result.
  - oCout = carry out of bit DW-1.
  - oOvf = (A[DW-1] == B'[DW-1]) && (oZ[DW-1] != A[DW-1]).
- Latency: a beat accepted at edge t appears with oValid=1 after edge t+NSTAGE, provided there is no stall.
- Handshake:
  - Advance enable en = !oValid || iReady. oReady = en, combinational from oValid and iReady only.
  - A beat transfers in when iValid && oReady. A result transfers out when oValid && iReady.
- Stall: when en=0 the whole pipe freezes, including bubbles. oZ, oCout, oOvf and oValid hold stable until accepted, with no glitching of the data fields.
- Bubbles: with iValid=0 and en=1, a zero valid bit enters stage 0. The data path of invalid stages may toggle; outputs are meaningful only when oValid=1.
- Throughput: one beat per cycle while iReady=1.
- Simultaneous in/out with a full pipe and iReady=1: both transfers occur in the same cycle; no loss, no duplication.
- Wrap-around: the result is modulo 2^DW. 0xFFFF+1 gives 0x0000 with oCout=1.
- Reset mid-operation: all in-flight beats are discarded with no output; oValid=0 on the next cycle.
- NSTAGE=1: degenerates to a registered single-segment adder; latency 1.
- Input stability: iA, iB, iCin and iSub are sampled only on a transfer cycle. Upstream may change them when iValid=0.

Optional Feature:
- Macro PIPE_ADDER_DW_SAT_EN.
- Defined: signed saturation is applied at the last stage. On oOvf=1, oZ is clamped:
  - positive overflow (A[DW-1]=0) gives 0x7F..F;
  - negative overflow gives 0x80..0;
  - oOvf still reports 1 and oCout is unchanged.
- Not defined: oZ is the raw modulo result; no saturation logic is present.

Test Plan:
- DW=16, NSTAGE=4, iA=0xFFFF, iB=0x0001, iSub=0, iCin=0, iReady=1 -> exactly 4 cycles later oValid=1, oZ=0x0000, oCout=1, oOvf=0.
- iA=0x0005, iB=0x0007, iSub=1, iCin=1 (ignored) -> oZ=0xFFFE, oCout=0, oOvf=0; then iA=0x1234, iB=0x0FFF, iCin=1, iSub=0 -> oZ=0x2234, oCout=0.
- iA=0x7FFF, iB=0x0001, add -> oZ=0x8000, oOvf=1; iA=0x8000, iB=0x0001, iSub=1 -> oZ=0x7FFF, oOvf=1. With PIPE_ADDER_DW_SAT_EN: 0x7FFF and 0x8000 respectively, oOvf=1.
- Stream 8 beats (A=n, B=0x0100*n, n=1..8) with iValid held high; drop iReady for 3 cycles once oValid=1 -> oReady=0 during the stall, oZ held stable, all 8 results in order (0x0101, 0x0202, ...), none dropped or duplicated.
- Load 3 beats, assert iReset for 1 cycle mid-flight -> oValid=0 on the next cycle and stays 0 for ≥NSTAGE cycles; the next accepted beat 0x0001+0x0002 yields 0x0003 after 4 cycles.
- NSTAGE=1, DW=8: iA=0x80, iB=0x80 -> the next cycle gives oZ=0x00, oCout=1, oOvf=1; back-to-back beats every cycle at full rate.
